// File: rtl/edge_window_if.sv
// Signal bundle between the edge-window sequencer and its consumers
// (bucket decoder, LED driver) plus the run/input controls.
interface edge_window_if;
  logic       enable;
  logic       sig_in;
  logic [7:0] edge_count_latched;
  logic       count_valid;
  logic       overflow;
  logic [7:0] peak_count;
  logic       busy;
  logic [1:0] state_dbg;

  // count_valid is a one-cycle strobe with no ready: the consumer must take
  // edge_count_latched/overflow/peak_count in the strobe cycle; they then hold.
  modport master (
    output enable, sig_in,
    input  edge_count_latched, count_valid, overflow, peak_count, busy, state_dbg
  );

  modport slave (
    input  enable, sig_in,
    output edge_count_latched, count_valid, overflow, peak_count, busy, state_dbg
  );
endinterface

// File: rtl/edge_window_ctrl.sv
// Counts synchronized rising edges of sig_in over back-to-back windows of
// WINDOW_CYCLES clocks, latches a saturated 8-bit count and a decaying peak.
module edge_window_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 480000,
  parameter int unsigned HOLD_WINDOWS  = 8,
  parameter int unsigned DECAY_STEP    = 8
) (
  input logic        clk,
  input logic        reset_n,
  edge_window_if.slave bus
);

  localparam int unsigned TW = $clog2(WINDOW_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [TW-1:0] LAST     = TW'(WINDOW_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_WINDOWS);
  localparam logic [7:0]    DEC      = 8'(DECAY_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t state, state_nx;

  logic          s1, s2, s3;
  logic [TW-1:0] timer;
  logic [7:0]    count;
  logic [7:0]    latched;
  logic          ovf;
  logic          valid;
  logic [7:0]    peak;
  logic [HW-1:0] hold;

  logic          edge_pulse;
  logic [8:0]    sum9;
  logic [7:0]    sum_sat;
  logic          win_done;
  logic [7:0]    peak_nx;
  logic [HW-1:0] hold_nx;
  logic [7:0]    decayed;

  assign edge_pulse = s2 & ~s3;
  assign sum9       = {1'b0, count} + {8'd0, edge_pulse};
  assign sum_sat    = sum9[8] ? 8'hFF : sum9[7:0];
  // enable low beats a coincident terminal cycle, so no latch on the way out
  assign win_done   = (state == COUNT) && (timer == LAST) && bus.enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.enable) state_nx = ARM;
      ARM:     state_nx = bus.enable ? COUNT : IDLE;
      COUNT:   if (!bus.enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    peak_nx = peak;
    hold_nx = hold;
    decayed = (peak > DEC) ? (peak - DEC) : 8'd0;
    if (sum_sat >= peak) begin
      peak_nx = sum_sat;
      hold_nx = '0;
    end else if (hold < HOLD_MAX) begin
      hold_nx = hold + HW'(1);
    end else begin
      peak_nx = (decayed > sum_sat) ? decayed : sum_sat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      timer   <= '0;
      count   <= '0;
      latched <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      peak    <= '0;
      hold    <= '0;
    end else begin
      s1    <= bus.sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      if (state == COUNT && bus.enable) begin
        if (win_done) begin
          timer   <= '0;
          count   <= '0;
          latched <= sum_sat;
          ovf     <= sum9[8] | (count == 8'hFF);
          valid   <= 1'b1;
          peak    <= peak_nx;
          hold    <= hold_nx;
        end else begin
          timer <= timer + TW'(1);
          count <= sum_sat;
        end
      end else begin
        timer <= '0;
        count <= '0;
      end
    end
  end

  assign bus.edge_count_latched = latched;
  assign bus.count_valid        = valid;
  assign bus.overflow           = ovf;
  assign bus.peak_count         = peak;
  assign bus.busy               = (state != IDLE);
  assign bus.state_dbg          = state;

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Bench for edge_window_ctrl: a 16-cycle-window instance for timing and enable
// handling, a 1024-cycle-window instance for saturation and peak decay.
module tb_edge_window_ctrl;
  localparam int W0   = 16;
  localparam int W1   = 1024;
  localparam int H    = 2;
  localparam int D    = 4;
  localparam int MAXC = 20000;

  // clock / reset block
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  edge_window_if bus0();
  edge_window_if bus1();

  edge_window_ctrl #(.WINDOW_CYCLES(W0), .HOLD_WINDOWS(H), .DECAY_STEP(D)) dut0 (
    .clk(clk), .reset_n(rst0), .bus(bus0.slave)
  );
  edge_window_ctrl #(.WINDOW_CYCLES(W1), .HOLD_WINDOWS(H), .DECAY_STEP(D)) dut1 (
    .clk(clk), .reset_n(rst1), .bus(bus1.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit done0  = 1'b0;
  bit done1  = 1'b0;

  // behavioural model state, one slot per instance
  bit   sig_h [2][MAXC];
  int   en_run [2];
  int   wcyc [2] = '{W0, W1};
  int   m_lat [2];
  int   m_pk [2];
  int   m_hold [2];
  logic m_ovf [2];
  logic m_valid [2];
  logic m_busy [2];

  // scoreboard queues of hand-computed per-window results
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] pk1_q[$];
  logic [0:0] ovf1_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Window results from the recorded input history: a rise seen by the
  // synchronizer two clocks late, counted when inside the window's cycles.
  function automatic void model_step(input int i, input logic rst, input logic en, input logic sig);
    int cnt, last, r, v, dec;
    if (!rst) begin
      sig_h[i][cyc] = 1'b0;
      en_run[i] = 0;
      m_lat[i] = 0; m_pk[i] = 0; m_hold[i] = 0;
      m_ovf[i] = 1'b0; m_valid[i] = 1'b0; m_busy[i] = 1'b0;
      return;
    end
    sig_h[i][cyc] = sig;
    m_valid[i] = 1'b0;
    en_run[i] = en ? en_run[i] + 1 : 0;
    m_busy[i] = en;
    if (en_run[i] > 2 && ((en_run[i] - 2) % wcyc[i]) == 0) begin
      cnt = 0;
      last = 0;
      for (int j = cyc - wcyc[i]; j < cyc; j++) begin
        r = (j >= 2 && sig_h[i][j-1] && !sig_h[i][j-2]) ? 1 : 0;
        cnt += r;
        if (j == cyc - 1) last = r;
      end
      v = (cnt > 255) ? 255 : cnt;
      m_lat[i] = v;
      m_ovf[i] = (cnt - last) >= 255;
      m_valid[i] = 1'b1;
      if (v >= m_pk[i]) begin
        m_pk[i] = v;
        m_hold[i] = 0;
      end else if (m_hold[i] < H) begin
        m_hold[i]++;
      end else begin
        dec = (m_pk[i] > D) ? m_pk[i] - D : 0;
        m_pk[i] = (dec > v) ? dec : v;
      end
    end
  endfunction

  initial begin : model_proc
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc >= MAXC - 10) begin
        errors++;
        $display("FAIL watchdog: cycle budget %0d exhausted", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      model_step(0, rst0, bus0.enable, bus0.sig_in);
      model_step(1, rst1, bus1.enable, bus1.sig_in);
    end
  end

  task automatic compare_dut(input int i, input logic rst, input logic [7:0] lat, input logic v,
                             input logic ov, input logic [7:0] pk, input logic bsy, input logic [1:0] st);
    if (!rst) begin
      check($sformatf("rst_lat%0d", i), lat, 0);
      check($sformatf("rst_valid%0d", i), v, 0);
      check($sformatf("rst_ovf%0d", i), ov, 0);
      check($sformatf("rst_peak%0d", i), pk, 0);
      check($sformatf("rst_busy%0d", i), bsy, 0);
      check($sformatf("rst_state%0d", i), st, 0);
    end else begin
      check($sformatf("lat%0d", i), lat, m_lat[i]);
      check($sformatf("valid%0d", i), v, m_valid[i]);
      check($sformatf("ovf%0d", i), ov, m_ovf[i]);
      check($sformatf("peak%0d", i), pk, m_pk[i]);
      check($sformatf("busy%0d", i), bsy, m_busy[i]);
      check($sformatf("state_idle%0d", i), (st == 2'd0), !m_busy[i]);
    end
  endtask

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      compare_dut(0, rst0, bus0.edge_count_latched, bus0.count_valid, bus0.overflow,
                  bus0.peak_count, bus0.busy, bus0.state_dbg);
      compare_dut(1, rst1, bus1.edge_count_latched, bus1.count_valid, bus1.overflow,
                  bus1.peak_count, bus1.busy, bus1.state_dbg);
    end
  end

  initial begin : scoreboard_proc
    forever begin
      @(negedge clk);
      if (rst0 && bus0.count_valid) begin
        if (exp0_q.size() == 0) check("unexpected_strobe0", 1, 0);
        else check("sb_lat0", bus0.edge_count_latched, exp0_q.pop_front());
      end
      if (rst1 && bus1.count_valid) begin
        if (exp1_q.size() == 0) check("unexpected_strobe1", 1, 0);
        else begin
          check("sb_lat1", bus1.edge_count_latched, exp1_q.pop_front());
          if (pk1_q.size() != 0) check("sb_peak1", bus1.peak_count, pk1_q.pop_front());
          if (ovf1_q.size() != 0) check("sb_ovf1", bus1.overflow, ovf1_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulses0(input int n);
    for (int p = 0; p < n; p++) begin
      bus0.sig_in = 1'b1; edges(1);
      bus0.sig_in = 1'b0; edges(1);
    end
  endtask

  task automatic pulses1(input int n);
    for (int p = 0; p < n; p++) begin
      bus1.sig_in = 1'b1; edges(2);
      bus1.sig_in = 1'b0; edges(2);
    end
  endtask

  task automatic wait_strobe0(output int at);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!bus0.count_valid && b < 40);
    check("strobe0_seen", bus0.count_valid, 1);
    at = cyc;
  endtask

  task automatic wait_strobe1(output int at);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!bus1.count_valid && b < 1100);
    check("strobe1_seen", bus1.count_valid, 1);
    at = cyc;
  endtask

  initial begin : drv0
    int k, l1, l2, t;
    rst0 = 1'b0; bus0.enable = 1'b0; bus0.sig_in = 1'b0;
    edges(3);
    rst0 = 1'b1;
    edges(3);
    check("idle_lat0", bus0.edge_count_latched, 0);
    check("idle_peak0", bus0.peak_count, 0);
    check("idle_busy0", bus0.busy, 0);

    // basic count: 5 edges then a quiet window
    exp0_q.push_back(8'd5); exp0_q.push_back(8'd0);
    bus0.enable = 1'b1;
    k = cyc + 1;
    edges(1);
    check("busy_after_enable", bus0.busy, 1);
    edges(1);
    pulses0(5);
    wait_strobe0(l1);
    check("first_strobe_cycle", l1, k + 1 + W0);
    wait_strobe0(l2);
    check("strobe_spacing", l2 - l1, W0);

    // terminal-cycle edge counts here; one cycle later goes to the next window
    exp0_q.push_back(8'd1); exp0_q.push_back(8'd0); exp0_q.push_back(8'd1);
    edges(13);
    bus0.sig_in = 1'b1; edges(1); bus0.sig_in = 1'b0;
    wait_strobe0(t);
    edges(14);
    bus0.sig_in = 1'b1; edges(1); bus0.sig_in = 1'b0;
    wait_strobe0(t);
    wait_strobe0(t);

    // sig_in already high when enable rises
    edges(1);
    bus0.enable = 1'b0; bus0.sig_in = 1'b1;
    edges(4);
    bus0.enable = 1'b1;
    exp0_q.push_back(8'd0);
    wait_strobe0(t);
    bus0.sig_in = 1'b0;
    exp0_q.push_back(8'd3);
    edges(2);
    pulses0(3);
    wait_strobe0(t);

    // enable dropped at timer 10: partial window discarded
    edges(2);
    pulses0(2);
    edges(4);
    bus0.enable = 1'b0;
    edges(1);
    check("busy_falls", bus0.busy, 0);
    edges(30);
    check("retained_lat", bus0.edge_count_latched, 3);
    check("retained_peak", bus0.peak_count, 3);

    // reset mid-window, release with enable low
    bus0.enable = 1'b1;
    edges(10);
    rst0 = 1'b0; bus0.enable = 1'b0;
    edges(2);
    rst0 = 1'b1;
    edges(100);
    check("post_rst_lat", bus0.edge_count_latched, 0);
    check("post_rst_peak", bus0.peak_count, 0);
    check("post_rst_ovf", bus0.overflow, 0);
    check("post_rst_busy", bus0.busy, 0);
    done0 = 1'b1;
  end

  initial begin : drv1
    int t;
    logic [7:0] pk_tab [13];
    pk_tab = '{8'd40, 8'd40, 8'd40, 8'd36, 8'd32, 8'd28, 8'd24, 8'd20, 8'd16, 8'd12, 8'd10, 8'd10, 8'd50};
    rst1 = 1'b0; bus1.enable = 1'b0; bus1.sig_in = 1'b0;
    edges(3);
    rst1 = 1'b1;
    edges(2);

    // saturation: toggling every clock, then a quiet window
    exp1_q.push_back(8'd255); ovf1_q.push_back(1'b1); pk1_q.push_back(8'd255);
    exp1_q.push_back(8'd0);   ovf1_q.push_back(1'b0); pk1_q.push_back(8'd255);
    bus1.enable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus1.sig_in = ~bus1.sig_in;
      edges(1);
    end
    bus1.sig_in = 1'b0;
    wait_strobe1(t);
    wait_strobe1(t);

    // peak hold and decay from a fresh reset
    edges(1);
    rst1 = 1'b0; bus1.enable = 1'b0;
    edges(3);
    rst1 = 1'b1;
    edges(2);
    exp1_q.push_back(8'd40);
    for (int i = 0; i < 11; i++) exp1_q.push_back(8'd10);
    exp1_q.push_back(8'd50);
    for (int i = 0; i < 13; i++) begin
      pk1_q.push_back(pk_tab[i]);
      ovf1_q.push_back(1'b0);
    end
    bus1.enable = 1'b1;
    edges(3);
    pulses1(40);
    wait_strobe1(t);
    for (int i = 0; i < 11; i++) begin
      edges(2);
      pulses1(10);
      wait_strobe1(t);
    end
    edges(2);
    pulses1(50);
    wait_strobe1(t);
    bus1.enable = 1'b0;
    edges(2);
    done1 = 1'b1;
  end

  initial begin : report_proc
    wait (done0 && done1);
    check("exp0_drained", exp0_q.size(), 0);
    check("exp1_drained", exp1_q.size(), 0);
    check("pk1_drained", pk1_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
